reset_sequencer: RTL and testbench

Sequences reset release for the processor and its peripherals. It sits directly downstream of the clock divisor and is clocked by the divided core clock. It waits for a stable PLL lock, releases peripheral reset first and core reset second, and supports a processor-requested soft reset that re-resets the core only. Any loss of lock returns the whole system to reset.

---
 rtl/reset_sequencer.sv | 123 ++++++++++++
 tb/tb_reset_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset release sequencer: waits for a stable PLL lock, frees the peripherals,
// then the core, and services processor soft-reset requests on the core only.
module reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int CORE_DELAY         = 8,
    parameter int SOFT_CYCLES        = 4,
    parameter int CNT_WIDTH          = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       soft_reset_req,
    output logic       periph_reset_n,
    output logic       core_reset_n,
    output logic       ready,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        PERIPH    = 3'd2,
        RUN       = 3'd3,
        SOFT      = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PERIPH_LAST = CNT_WIDTH'(CORE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] SOFT_LAST   = CNT_WIDTH'(SOFT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q;
    state_t                 nxt_state;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   nxt_cnt;

    // pll_lock is asynchronous to clk; nothing else may look at it directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        nxt_state = state_q;
        nxt_cnt   = cnt_q;
        if ((state_q != WAIT_LOCK) && !lock_s) begin
            nxt_state = WAIT_LOCK;
            nxt_cnt   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt_state = STABLE;
                        nxt_cnt   = '0;
                    end
                end
                STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        nxt_state = PERIPH;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt_q + CNT_ONE;
                    end
                end
                PERIPH: begin
                    if (cnt_q == PERIPH_LAST) begin
                        nxt_state = RUN;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (soft_reset_req) begin
                        nxt_state = SOFT;
                        nxt_cnt   = '0;
                    end
                end
                SOFT: begin
                    // requests are ignored here; a held request re-enters after one RUN cycle
                    if (cnt_q == SOFT_LAST) begin
                        nxt_state = RUN;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    nxt_state = WAIT_LOCK;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            periph_reset_n <= 1'b0;
            core_reset_n   <= 1'b0;
            ready          <= 1'b0;
        end else begin
            state_q        <= nxt_state;
            cnt_q          <= nxt_cnt;
            periph_reset_n <= (nxt_state == PERIPH) || (nxt_state == RUN) || (nxt_state == SOFT);
            core_reset_n   <= (nxt_state == RUN);
            ready          <= (nxt_state == RUN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table, directed corner sequences, and a
// randomized run checked against a timeline-based reference model.
module tb_reset_sequencer;

    localparam int SS   = 2;
    localparam int LSC  = 16;
    localparam int CD   = 8;
    localparam int SOFT = 4;
    localparam int CW   = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       soft_reset_req;
    logic       periph_reset_n;
    logic       core_reset_n;
    logic       ready;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    // Reference model: t = edges since STABLE was entered (-1 = waiting for lock),
    // soft_left = remaining SOFT cycles once the sequence has reached RUN.
    int            m_t;
    int            m_soft_left;
    logic [SS-1:0] m_hist;

    reset_sequencer #(
        .SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(LSC), .CORE_DELAY(CD),
        .SOFT_CYCLES(SOFT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock),
        .soft_reset_req(soft_reset_req), .periph_reset_n(periph_reset_n),
        .core_reset_n(core_reset_n), .ready(ready), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        bit         lock;
        bit         req;
        logic [2:0] st;
        bit         pr;
        bit         cr;
        bit         rdy;
    } vec_t;

    vec_t vt[16];

    task automatic model_reset();
        m_t = -1;
        m_soft_left = 0;
        m_hist = '0;
    endtask

    task automatic model_edge();
        logic ls;
        ls = m_hist[SS-1];
        m_hist = {m_hist[SS-2:0], pll_lock};
        if (!ls) begin
            m_t = -1;
            m_soft_left = 0;
        end else if (m_t < 0) begin
            m_t = 0;
        end else if (m_t >= LSC + CD) begin
            if (m_soft_left > 0) m_soft_left = m_soft_left - 1;
            else if (soft_reset_req) m_soft_left = SOFT;
        end else begin
            m_t = m_t + 1;
        end
    endtask

    function automatic logic [5:0] model_exp();
        logic [2:0] st;
        logic pr, cr;
        if (m_t < 0)             st = 3'd0;
        else if (m_t < LSC)      st = 3'd1;
        else if (m_t < LSC + CD) st = 3'd2;
        else if (m_soft_left > 0) st = 3'd4;
        else                     st = 3'd3;
        pr = (m_t >= LSC);
        cr = (m_t >= LSC + CD) && (m_soft_left == 0);
        return {st, pr, cr, cr};
    endfunction

    function automatic logic [5:0] dut_act();
        return {state, periph_reset_n, core_reset_n, ready};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got state=%0d periph=%b core=%b ready=%b, want state=%0d periph=%b core=%b ready=%b",
                     name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", dut_act(), model_exp());
    endtask

    task automatic async_reset_pulse(input string name);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk(name, dut_act(), 6'b000_000);
        reset_n = 1'b1;
    endtask

    initial begin
        int stable_at, periph_at, edge_i;
        logic [2:0] exp_held [11];

        vt[0]  = '{2,  1, 0, 3'd0, 0, 0, 0};
        vt[1]  = '{1,  1, 0, 3'd1, 0, 0, 0};
        vt[2]  = '{15, 1, 0, 3'd1, 0, 0, 0};
        vt[3]  = '{1,  1, 0, 3'd2, 1, 0, 0};
        vt[4]  = '{7,  1, 1, 3'd2, 1, 0, 0};
        vt[5]  = '{1,  1, 0, 3'd3, 1, 1, 1};
        vt[6]  = '{5,  1, 0, 3'd3, 1, 1, 1};
        vt[7]  = '{1,  1, 1, 3'd4, 1, 0, 0};
        vt[8]  = '{3,  1, 0, 3'd4, 1, 0, 0};
        vt[9]  = '{1,  1, 0, 3'd3, 1, 1, 1};
        vt[10] = '{2,  0, 0, 3'd3, 1, 1, 1};
        vt[11] = '{1,  0, 0, 3'd0, 0, 0, 0};
        vt[12] = '{2,  1, 0, 3'd0, 0, 0, 0};
        vt[13] = '{1,  1, 0, 3'd1, 0, 0, 0};
        vt[14] = '{16, 1, 0, 3'd2, 1, 0, 0};
        vt[15] = '{8,  1, 0, 3'd3, 1, 1, 1};
        exp_held = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3};

        reset_n = 1'b0;
        pll_lock = 1'b0;
        soft_reset_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_act(), 6'b000_000);

        // Power-up, PERIPH-time request, soft reset, lock loss and recovery
        pll_lock = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pll_lock = vt[i].lock;
            soft_reset_req = vt[i].req;
            for (int k = 0; k < vt[i].n; k++) step();
            chk($sformatf("vec%0d", i), dut_act(), {vt[i].st, vt[i].pr, vt[i].cr, vt[i].rdy});
        end
        soft_reset_req = 1'b0;

        // Asynchronous reset in the middle of PERIPH, then a full repeat
        async_reset_pulse("rst_pre");
        repeat (21) step();
        chk("in_periph", dut_act(), {3'd2, 3'b100});
        async_reset_pulse("rst_mid_periph");
        repeat (19) step();
        chk("rerun_periph", dut_act(), {3'd2, 3'b100});
        repeat (8) step();
        chk("rerun_run", dut_act(), {3'd3, 3'b111});

        // Lock glitch at STABLE cnt=10 must restart the full stable window
        async_reset_pulse("rst_glitch");
        repeat (13) step();
        chk("stable_cnt10", dut_act(), {3'd1, 3'b000});
        pll_lock = 1'b0;
        repeat (3) step();
        pll_lock = 1'b1;
        stable_at = -1;
        periph_at = -1;
        edge_i = 0;
        while (periph_at < 0 && edge_i < 80) begin
            step();
            edge_i++;
            if (stable_at < 0 && state == 3'd1) stable_at = edge_i;
            if (stable_at >= 0 && periph_reset_n) periph_at = edge_i;
        end
        checks++;
        if (stable_at < 0 || periph_at - stable_at != LSC) begin
            failures++;
            $display("FAIL glitch_window: got %0d edges (stable_at=%0d periph_at=%0d), want %0d",
                     periph_at - stable_at, stable_at, periph_at, LSC);
        end

        // Held soft-reset request from RUN
        repeat (CD + 1) step();
        chk("pre_held_run", dut_act(), {3'd3, 3'b111});
        soft_reset_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) soft_reset_req = 1'b0;
            step();
            chk($sformatf("held%0d", i), {state, 3'b000}, {exp_held[i], 3'b000});
        end

        // Lock loss during SOFT
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        pll_lock = 1'b0;
        repeat (2) step();
        chk("soft_lockloss_a", dut_act(), {3'd4, 3'b100});
        step();
        chk("soft_lockloss_b", dut_act(), {3'd0, 3'b000});

        // Randomized run against the reference model
        for (int c = 0; c < 4000; c++) begin
            if (pll_lock) pll_lock = ($urandom_range(0, 149) != 0);
            else          pll_lock = ($urandom_range(0, 3) == 0);
            soft_reset_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 799) == 0) async_reset_pulse("rnd_rst");
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
